mac_feeder: RTL

- Upstream stage of the 21-bit accumulating register in each MLP neuron.
- Accepts a stream of NUM_IN signed 8-bit activation/weight pairs over a valid/ready handshake.
- Registers each signed product, sign-extended to PW bits, and drives the accumulator's load and accumulate strobes.
- Pulses done once the accumulator holds the complete dot product; drives the element index used to address the input and weight memories.

---
 rtl/mac_feeder.sv | 109 ++++++++++
 1 files changed

// File: rtl/mac_feeder.sv
// mac_feeder: feeds registered signed products and load/accumulate strobes
// to a PW-bit accumulator for one NUM_IN-element dot product.
// Optional build macro MAC_ZERO_SKIP_EN: suppresses the strobe for
// non-first pairs with a zero operand (power saving; same final sum).
module mac_feeder #(
  parameter int unsigned DW     = 8,
  parameter int unsigned PW     = 21,
  parameter int unsigned NUM_IN = 62,
  parameter int unsigned IW     = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] x_in,
  input  logic [DW-1:0] w_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [IW-1:0] idx,
  output logic [PW-1:0] prod_out,
  output logic          acc_ld,
  output logic          acc_en,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  localparam logic [IW-1:0] LastIdx = IW'(NUM_IN - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [PW-1:0] prod_q, prod_d;
  logic          ld_q, ld_d;
  logic          en_q, en_d;

  logic                   accept;
  logic                   is_first;
  logic                   is_last;
  logic                   skip;
  logic signed [2*DW-1:0] prod_full;
  logic        [PW-1:0]   prod_ext;

  assign accept    = in_valid && (state_q == StRun);
  assign is_first  = (idx_q == '0);
  assign is_last   = (idx_q == LastIdx);
  assign prod_full = $signed(x_in) * $signed(w_in);
  assign prod_ext  = {{(PW - 2*DW){prod_full[2*DW-1]}}, prod_full};

`ifdef MAC_ZERO_SKIP_EN
  // Pair 0 always loads so a stale sum is overwritten even by a zero product.
  assign skip = !is_first && ((x_in == '0) || (w_in == '0));
`else
  assign skip = 1'b0;
`endif

  // Next-state, index, product and strobe decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    prod_d  = prod_q;
    ld_d    = 1'b0;
    en_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        if (accept) begin
          idx_d = is_last ? '0 : idx_q + 1'b1;
          if (!skip) begin
            prod_d = prod_ext;
            ld_d   = is_first;
            en_d   = !is_first;
          end
          if (is_last) state_d = StFlush;
        end
      end
      StFlush: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      prod_q  <= '0;
      ld_q    <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      prod_q  <= prod_d;
      ld_q    <= ld_d;
      en_q    <= en_d;
    end
  end

  assign in_ready = (state_q == StRun);
  assign busy     = (state_q == StRun) || (state_q == StFlush);
  assign done     = (state_q == StDone);
  assign idx      = idx_q;
  assign prod_out = prod_q;
  assign acc_ld   = ld_q;
  assign acc_en   = en_q;

endmodule
